// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
//   Stall/flush sequencer for the 5-stage core. Produces the per-stage advance
//   enables, detects load-use hazards against the load in execute, freezes the
//   whole pipe during a memory stall and runs a multi-cycle front-end squash
//   after an execute-stage mispredict.
//
// Parameters
//   FLUSH_CYCLES  cycles flush_front stays high after a mispredict (1..15)
//   CNT_W         width of the performance counters
//
// Optional build macro
//   PERF_COUNTERS_EN  when defined, stall/flush performance counters are
//                     implemented; otherwise both count outputs are tied to 0.
//
// Ports
//   i_clk, i_reset               clock, asynchronous active-high reset
//   i_decode_*                   decode instruction valid/sources/source-use
//   i_exec_valid/_is_load/_rd    execute instruction valid/load/destination
//   i_fetch_mispredict           redirect request from execute pc control
//   i_mem_req, i_mem_ready       memory access outstanding / completing
//   o_*_advance                  per-stage pipeline register enables
//   o_flush_front                invalidate fetch and decode contents
//   o_ctrl_state                 0=RUN 1=FLUSH 2=MEM_WAIT
//   o_stall_count                cycles with execute_advance=0 (saturating)
//   o_flush_count                accepted mispredicts (saturating)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal flow, load-use bubbles inserted as needed
// FLUSH    | front-end squash in progress, counter tracks remaining cycles
// MEM_WAIT | whole pipe frozen on memory; pending flush replays on release
// ---------------------------------------------------------------------------
module pipeline_controller #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_decode_valid,
   input  logic [4:0]       i_decode_rs1,
   input  logic [4:0]       i_decode_rs2,
   input  logic             i_decode_uses_rs1,
   input  logic             i_decode_uses_rs2,
   input  logic             i_exec_valid,
   input  logic             i_exec_is_load,
   input  logic [4:0]       i_exec_rd,
   input  logic             i_fetch_mispredict,
   input  logic             i_mem_req,
   input  logic             i_mem_ready,
   output logic             o_fetch_advance,
   output logic             o_decode_advance,
   output logic             o_execute_advance,
   output logic             o_memory_advance,
   output logic             o_writeback_advance,
   output logic             o_flush_front,
   output logic [1:0]       o_ctrl_state,
   output logic [CNT_W-1:0] o_stall_count,
   output logic [CNT_W-1:0] o_flush_count
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       r_pending;
   logic       w_pending_nxt;
   logic [4:0] w_adv;        // {fetch, decode, execute, memory, writeback}
   logic       w_flush;
   logic       w_mem_stall;
   logic       w_load_use;

   assign w_mem_stall = i_mem_req & ~i_mem_ready;

   // exec_rd==0 is the hard-wired zero register and never creates a dependency
   assign w_load_use = i_decode_valid & i_exec_valid & i_exec_is_load &
                       (i_exec_rd != 5'd0) &
                       ((i_decode_uses_rs1 & (i_decode_rs1 == i_exec_rd)) |
                        (i_decode_uses_rs2 & (i_decode_rs2 == i_exec_rd)));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= ST_RUN;
         r_cnt     <= 4'd0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pending_nxt = r_pending;
      w_adv         = 5'b11111;
      w_flush       = 1'b0;

      if (w_mem_stall) begin
         w_adv       = 5'b00000;
         w_state_nxt = ST_MEM_WAIT;
         // a stall that interrupts FLUSH restarts the whole squash on release
         if (i_fetch_mispredict || (r_state == ST_FLUSH)) begin
            w_pending_nxt = 1'b1;
         end
      end else if (i_fetch_mispredict || r_pending) begin
         w_flush       = 1'b1;
         w_cnt_nxt     = FLUSH_LOAD;
         w_pending_nxt = 1'b0;
         w_state_nxt   = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
      end else if (r_state == ST_FLUSH) begin
         // decode is being discarded, so no load-use check here
         w_flush   = 1'b1;
         w_cnt_nxt = r_cnt - 4'd1;
         if (r_cnt <= 4'd1) begin
            w_state_nxt = ST_RUN;
         end
      end else begin
         w_state_nxt = ST_RUN;
         if (w_load_use) begin
            w_adv = 5'b00011;
         end
      end
   end

   assign o_fetch_advance     = w_adv[4] & ~i_reset;
   assign o_decode_advance    = w_adv[3] & ~i_reset;
   assign o_execute_advance   = w_adv[2] & ~i_reset;
   assign o_memory_advance    = w_adv[1] & ~i_reset;
   assign o_writeback_advance = w_adv[0] & ~i_reset;
   assign o_flush_front       = w_flush  & ~i_reset;
   assign o_ctrl_state        = r_state;

`ifdef PERF_COUNTERS_EN
   logic [CNT_W-1:0] r_stall_count;
   logic [CNT_W-1:0] r_flush_count;
   logic             w_flush_accept;

   assign w_flush_accept = ~w_mem_stall & (i_fetch_mispredict | r_pending);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (!w_adv[2] && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
         end
         if (w_flush_accept && (r_flush_count != '1)) begin
            r_flush_count <= r_flush_count + 1'b1;
         end
      end
   end

   assign o_stall_count = r_stall_count;
   assign o_flush_count = r_flush_count;
`else
   assign o_stall_count = '0;
   assign o_flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

   localparam int FC    = 3;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;
`ifdef PERF_COUNTERS_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic       dv;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       ev;
      logic       ld;
      logic [4:0] rd;
      logic       mp;
      logic       mreq;
      logic       mrdy;
   } in_t;

   typedef struct packed {
      in_t        in;
      logic [4:0] adv;
      logic       fl;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   in_t  cur;
   logic o_fa, o_da, o_ea, o_ma, o_wa, o_ff;
   logic [1:0]    o_st;
   logic [CW-1:0] o_sc, o_fcnt;

   int n_checks = 0;
   int n_err    = 0;

   // reference model: remaining squash cycles, frozen flag, deferred squash
   int m_left, m_stalls, m_flushes;
   bit m_wait, m_pend;

   logic [4:0] g_adv;
   logic       g_fl;
   logic [1:0] g_st;

   always #5 clk = ~clk;

   pipeline_controller #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .i_clk               (clk),
      .i_reset             (rst),
      .i_decode_valid      (cur.dv),
      .i_decode_rs1        (cur.rs1),
      .i_decode_rs2        (cur.rs2),
      .i_decode_uses_rs1   (cur.u1),
      .i_decode_uses_rs2   (cur.u2),
      .i_exec_valid        (cur.ev),
      .i_exec_is_load      (cur.ld),
      .i_exec_rd           (cur.rd),
      .i_fetch_mispredict  (cur.mp),
      .i_mem_req           (cur.mreq),
      .i_mem_ready         (cur.mrdy),
      .o_fetch_advance     (o_fa),
      .o_decode_advance    (o_da),
      .o_execute_advance   (o_ea),
      .o_memory_advance    (o_ma),
      .o_writeback_advance (o_wa),
      .o_flush_front       (o_ff),
      .o_ctrl_state        (o_st),
      .o_stall_count       (o_sc),
      .o_flush_count       (o_fcnt)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic in_t mk(input bit dv, input logic [4:0] rs1, input logic [4:0] rs2,
                              input bit u1, input bit u2, input bit ev, input bit ld,
                              input logic [4:0] rd, input bit mp, input bit mreq, input bit mrdy);
      in_t r;
      r.dv = dv; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
      r.ev = ev; r.ld = ld; r.rd = rd; r.mp = mp; r.mreq = mreq; r.mrdy = mrdy;
      return r;
   endfunction

   function automatic logic [4:0] adv_now();
      return {o_fa, o_da, o_ea, o_ma, o_wa};
   endfunction

   task automatic model_reset();
      m_left = 0; m_stalls = 0; m_flushes = 0; m_wait = 0; m_pend = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cur = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // one clock: apply inputs, compare against the model mid-cycle, then advance the model
   task automatic step(input in_t v);
      bit         stall, haz;
      logic [4:0] e_adv;
      bit         e_fl;
      int         e_st, n_left;
      bit         n_wait, n_pend;
      cur = v;
      @(negedge clk);
      stall = v.mreq && !v.mrdy;
      haz   = v.dv && v.ev && v.ld && (v.rd != 0) &&
              ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
      e_st   = m_wait ? 2 : ((m_left > 0) ? 1 : 0);
      n_left = m_left; n_wait = 0; n_pend = m_pend;
      e_fl   = 0;
      e_adv  = 5'b11111;
      if (stall) begin
         e_adv  = 5'b00000;
         n_pend = m_pend || v.mp || (m_left > 0);
         n_left = 0;
         n_wait = 1;
      end else if (v.mp || m_pend) begin
         e_fl   = 1;
         n_left = FC - 1;
         n_pend = 0;
      end else if (m_left > 0) begin
         e_fl   = 1;
         n_left = m_left - 1;
      end else if (haz) begin
         e_adv  = 5'b00011;
      end
      g_adv = adv_now(); g_fl = o_ff; g_st = o_st;
      chk("adv",         g_adv, e_adv);
      chk("flush_front", g_fl,  e_fl);
      chk("ctrl_state",  g_st,  e_st);
      chk("stall_count", o_sc,  PERF ? m_stalls  : 0);
      chk("flush_count", o_fcnt, PERF ? m_flushes : 0);
      @(posedge clk);
      if (!e_adv[2] && m_stalls < CMAX) m_stalls++;
      if (!stall && (v.mp || m_pend) && m_flushes < CMAX) m_flushes++;
      m_left = n_left; m_wait = n_wait; m_pend = n_pend;
      #1;
   endtask

   vec_t tv[17];
   in_t  idle, haz5;
   int   cnt;

   initial begin
      idle = '0;
      haz5 = mk(1, 0, 5, 0, 1, 1, 1, 5, 0, 0, 0);
      tv[0]  = '{mk(0,0,0,0,0,0,0,0,0,0,0), 5'b11111, 1'b0};
      tv[1]  = '{haz5,                        5'b00011, 1'b0};
      tv[2]  = '{mk(1,0,0,0,1,1,1,0,0,0,0), 5'b11111, 1'b0};
      tv[3]  = '{mk(1,0,5,0,0,1,1,5,0,0,0), 5'b11111, 1'b0};
      tv[4]  = '{mk(1,7,0,1,0,1,1,7,0,0,0), 5'b00011, 1'b0};
      tv[5]  = '{mk(1,7,0,0,0,1,1,7,0,0,0), 5'b11111, 1'b0};
      tv[6]  = '{mk(1,0,5,0,1,1,0,5,0,0,0), 5'b11111, 1'b0};
      tv[7]  = '{mk(1,0,5,0,1,0,1,5,0,0,0), 5'b11111, 1'b0};
      tv[8]  = '{mk(0,0,5,0,1,1,1,5,0,0,0), 5'b11111, 1'b0};
      tv[9]  = '{mk(1,0,5,0,1,1,1,5,1,0,0), 5'b11111, 1'b1};
      tv[10] = '{mk(0,0,0,0,0,0,0,0,0,1,0), 5'b00000, 1'b0};
      tv[11] = '{mk(1,0,5,0,1,1,1,5,1,1,0), 5'b00000, 1'b0};
      tv[12] = '{mk(0,0,0,0,0,0,0,0,0,1,1), 5'b11111, 1'b0};
      tv[13] = '{mk(1,0,5,0,1,1,1,5,0,0,1), 5'b00011, 1'b0};
      tv[14] = '{mk(1,3,9,1,1,1,1,9,0,0,0), 5'b00011, 1'b0};
      tv[15] = '{mk(0,0,0,0,0,0,0,0,1,0,0), 5'b11111, 1'b1};
      tv[16] = '{mk(1,0,5,0,1,1,1,5,0,1,0), 5'b00000, 1'b0};

      // reset state: outputs forced low even with idle inputs
      rst = 1'b1;
      cur = idle;
      model_reset();
      #12;
      chk("rst_adv",   adv_now(), 0);
      chk("rst_flush", o_ff, 0);
      chk("rst_state", o_st, 0);
      chk("rst_stall_count", o_sc, 0);
      chk("rst_flush_count", o_fcnt, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single-cycle decisions from a freshly reset RUN state
      for (int i = 0; i < 17; i++) begin
         do_reset();
         cur = tv[i].in;
         @(negedge clk);
         chk($sformatf("vec%0d_adv", i),   adv_now(), tv[i].adv);
         chk($sformatf("vec%0d_flush", i), o_ff,      tv[i].fl);
         @(posedge clk);
         #1;
      end

      // load-use bubble, then release, then no false stalls
      do_reset();
      step(haz5);
      chk("lu_bubble", g_adv, 5'b00011);
      step(mk(1, 0, 5, 0, 1, 0, 1, 5, 0, 0, 0));
      chk("lu_release", g_adv, 5'b11111);
      step(mk(1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
      step(mk(1, 0, 5, 0, 0, 1, 1, 5, 0, 0, 0));
      chk("lu_stall_count", o_sc, PERF ? 1 : 0);

      // single mispredict pulse: three squash cycles, state 1,1,0 afterwards
      do_reset();
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      cnt = g_fl;
      step(idle); cnt += g_fl; chk("mp_state1", g_st, 1);
      step(idle); cnt += g_fl; chk("mp_state2", g_st, 1);
      step(idle); cnt += g_fl; chk("mp_state3", g_st, 0);
      chk("mp_flush_len", cnt, 3);
      chk("mp_flush_count", o_fcnt, PERF ? 1 : 0);

      // mispredict during memory stall replays on release
      do_reset();
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(mk(0, 0, 0, 0, 0, 0, 0, 0, (i == 1), 1, 0));
         if (g_adv == 5'b00000 && !g_fl) cnt++;
      end
      chk("ms_frozen_cycles", cnt, 4);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      chk("ms_release_flush", g_fl, 1);
      chk("ms_release_adv", g_adv, 5'b11111);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step(idle);
         cnt += g_fl;
      end
      chk("ms_tail_flush", cnt, FC - 1);

      // re-mispredict in first squash cycle reloads the counter
      do_reset();
      cnt = 0;
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); cnt += g_fl;
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); cnt += g_fl;
      for (int i = 0; i < 4; i++) begin
         step(idle);
         cnt += g_fl;
      end
      chk("remp_flush_len", cnt, 4);
      chk("remp_flush_count", o_fcnt, PERF ? 2 : 0);

      // asynchronous reset in MEM_WAIT with a pending squash
      do_reset();
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      cur = idle;
      #1;
      chk("ar_pending_visible", o_ff, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("ar_adv", adv_now(), 0);
      chk("ar_flush", o_ff, 0);
      chk("ar_state", o_st, 0);
      chk("ar_stall_count", o_sc, 0);
      chk("ar_flush_count", o_fcnt, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      step(idle);
      chk("ar_no_replay", g_fl, 0);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         in_t v;
         if ($urandom_range(0, 399) == 0) do_reset();
         v.dv   = ($urandom_range(0, 3) != 0);
         v.rs1  = 5'($urandom_range(0, 3));
         v.rs2  = 5'($urandom_range(0, 3));
         v.u1   = 1'($urandom_range(0, 1));
         v.u2   = 1'($urandom_range(0, 1));
         v.ev   = ($urandom_range(0, 3) != 0);
         v.ld   = 1'($urandom_range(0, 1));
         v.rd   = 5'($urandom_range(0, 3));
         v.mp   = ($urandom_range(0, 9) == 0);
         v.mreq = ($urandom_range(0, 3) == 0);
         v.mrdy = 1'($urandom_range(0, 1));
         step(v);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
- Central stall/flush sequencer for the 5-stage core (fetch, decode, execute, memory, writeback).
- Generates the per-stage advance signals consumed by each stage's pipeline register. Detects load-use hazards against the instruction in execute.
- Holds the whole pipe while memory is busy.
- Sequences a multi-cycle front-end squash after an execute-stage mispredict redirect.

Parameters:
FLUSH_CYCLES, 2, cycles flush_front stays high after a mispredict (legal range 1..15)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
decode_valid  in  1  decode holds a valid instruction
decode_rs1  in  5  decode source register 1
decode_rs2  in  5  decode source register 2
decode_uses_rs1  in  1  decode instruction reads rs1
decode_uses_rs2  in  1  decode instruction reads rs2
exec_valid  in  1  execute holds a valid instruction
exec_is_load  in  1  execute instruction is a load
exec_rd  in  5  execute destination register
fetch_mispredict  in  1  redirect request from execute pc control
mem_req  in  1  memory stage has an outstanding access
mem_ready  in  1  memory access completes this cycle
fetch_advance  out  1  fetch register may update
decode_advance  out  1  decode register may update
execute_advance  out  1  execute register may update
memory_advance  out  1  memory register may update
writeback_advance  out  1  writeback register may update
flush_front  out  1  invalidate fetch and decode contents
ctrl_state  out  2  0=RUN 1=FLUSH 2=MEM_WAIT
stall_count  out  CNT_W  cycles with execute_advance=0
flush_count  out  CNT_W  number of accepted mispredicts

Behaviour:
Reset:
- Asynchronous; state=RUN, flush counter=0, pending_flush=0, perf counters=0.
- While reset is high, all advance outputs=0 and flush_front=0.

Outputs:
- All outputs are combinational from state plus current inputs (Mealy). Zero-cycle latency.

Priority, highest first:
- (1) Memory stall, when mem_req & !mem_ready:
  - All five advance signals=0 and flush_front=0.
  - Next state is MEM_WAIT.
  - If fetch_mispredict=1 in this cycle, set pending_flush=1.
- (2) Flush, when fetch_mispredict | pending_flush in RUN or MEM_WAIT-exit, or fetch_mispredict in FLUSH:
  - flush_front=1 and all advances=1.
  - Load FLUSH_CYCLES-1 into the counter and clear pending_flush.
  - Increment flush_count.
  - Next state is FLUSH, or RUN if FLUSH_CYCLES=1.
- (3) Load-use, when decode_valid & exec_valid & exec_is_load & exec_rd!=0 & ((decode_uses_rs1 & decode_rs1==exec_rd) | (decode_uses_rs2 & decode_rs2==exec_rd)):
  - fetch_advance=decode_advance=execute_advance=0; memory_advance=writeback_advance=1. This inserts one bubble into execute.
  - State is unchanged.
- (4) Otherwise all advances=1 and flush_front=0.

States:
- MEM_WAIT: stays while mem_req & !mem_ready. When mem_ready=1, all advances=1 that cycle. Next state is FLUSH if pending_flush, else RUN.
- FLUSH: flush_front=1 and all advances=1. Load-use detection is suppressed (decode content is being discarded). Counter decrements each cycle; at counter==0 the next state is RUN. A memory stall inside FLUSH holds the counter and moves to MEM_WAIT with pending_flush=1, so the full flush restarts on release.

Performance counters:
- stall_count increments each non-reset cycle with execute_advance=0 and saturates at all-ones.
- flush_count saturates at all-ones.

Boundary conditions:
- exec_rd=0 never stalls.
- The load-use hazard and fetch_mispredict in the same cycle resolve as flush (the dependent instruction is squashed).
- Reset asserted mid-FLUSH or mid-MEM_WAIT returns to RUN immediately with pending state cleared.

Optional Feature:
PERF_COUNTERS_EN
- Defined: stall_count and flush_count registers are implemented as above.
- Undefined: no counter flops; stall_count and flush_count are tied to 0; all other behaviour is identical.

Test Plan:
- Load-use: exec_valid=1, exec_is_load=1, exec_rd=5; decode_valid=1, decode_uses_rs2=1, decode_rs2=5 -> one cycle with fetch/decode/execute_advance=0, memory/writeback_advance=1; next cycle with exec_valid=0 -> all advances=1; stall_count=1.
- No false stall: same stimulus with exec_rd=0, or decode_uses_rs2=0 -> all advances=1 and stall_count stays 0.
- Mispredict, FLUSH_CYCLES=3: pulse fetch_mispredict for 1 cycle -> flush_front high for exactly 3 cycles; ctrl_state sequence 1,1,0 after the pulse cycle; flush_count=1.
- Mispredict during memory stall: mem_req=1, mem_ready=0 for 4 cycles with fetch_mispredict on cycle 2 -> all advances=0 and flush_front=0 for 4 cycles; on the mem_ready cycle flush_front=1 and all advances=1, then FLUSH runs for FLUSH_CYCLES-1 further cycles.
- Re-mispredict in FLUSH, FLUSH_CYCLES=3: second fetch_mispredict in the first FLUSH cycle -> counter reloads; flush_front high for 4 consecutive cycles total; flush_count=2.
- Async reset: assert reset mid-MEM_WAIT, asynchronous to clk -> outputs drop immediately to advances=0 and flush_front=0; after deassert, ctrl_state=0, counters=0, pending flush is discarded.
